// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl -- iterative 8-point NTT over Z_Q (default Q=17, OMEGA=2).
//
// One radix-2 decimation-in-time butterfly is time-shared across 3 stages x
// 4 butterflies, working in place on an 8-entry coefficient register file.
// Coefficients arrive in natural order and are stored bit-reversed, so the
// results can be read out in natural order.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts any transform)
//   ntt_start  start request, sampled only in IDLE
//   in_data    input coefficient a[i] (reduced mod Q on write)
//   in_valid   in_data valid
//   in_ready   high in LOAD
//   out_data   result X[k]; 0 whenever out_valid is low
//   out_valid  high in UNLOAD
//   out_ready  consumer accepts out_data
//   busy       high in any state other than IDLE
//   ntt_done   one-cycle pulse in the cycle after the final output beat
//   dbg_state  current FSM state (IDLE=0, LOAD=1, COMPUTE=2, UNLOAD=3)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holding valid high keeps its data stable until that edge;
// valid never depends on ready.
//
// Build option: define NTT_INTT_EN to add the 'inverse' input. It is sampled
// with ntt_start and selects OMEGA_INV twiddles plus a final N_INV scaling on
// the read path. Without it the block is forward-only.

module ntt_seq_ctrl #(
  parameter int W         = 8,
  parameter int Q         = 17,
  parameter int OMEGA     = 2,
  parameter int OMEGA_INV = 9,
  parameter int N_INV     = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ntt_start,
`ifdef NTT_INTT_EN
  input  logic         inverse,
`endif
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         ntt_done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } state_t;

  // Elaboration-time modular power used to build the twiddle table.
  function automatic int pow_mod(input int base, input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * base) % Q;
    return r;
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  localparam logic [W-1:0] QW     = W'(Q);
  localparam logic [W-1:0] NINV_W = W'(N_INV);
  localparam logic [W-1:0] TWF0   = W'(pow_mod(OMEGA, 0));
  localparam logic [W-1:0] TWF1   = W'(pow_mod(OMEGA, 1));
  localparam logic [W-1:0] TWF2   = W'(pow_mod(OMEGA, 2));
  localparam logic [W-1:0] TWF3   = W'(pow_mod(OMEGA, 3));
  localparam logic [W-1:0] TWI0   = W'(pow_mod(OMEGA_INV, 0));
  localparam logic [W-1:0] TWI1   = W'(pow_mod(OMEGA_INV, 1));
  localparam logic [W-1:0] TWI2   = W'(pow_mod(OMEGA_INV, 2));
  localparam logic [W-1:0] TWI3   = W'(pow_mod(OMEGA_INV, 3));

  state_t       state, state_nxt;
  logic [3:0]   cnt;      // load beat / butterfly / unload beat counter
  logic         done_q;
  logic         inv_q;
  logic         in_hs, out_hs;
  logic [W-1:0] rf [8];

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ntt_start)               state_nxt = LOAD;
      LOAD:    if (in_hs && cnt == 4'd7)    state_nxt = COMPUTE;
      COMPUTE: if (cnt == 4'd11)            state_nxt = UNLOAD;
      UNLOAD:  if (out_hs && cnt == 4'd7)   state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter and done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == UNLOAD) && out_hs && (cnt == 4'd7);
      case (state)
        IDLE:    cnt <= '0;
        LOAD:    if (in_hs)  cnt <= (cnt == 4'd7)  ? 4'd0 : cnt + 4'd1;
        COMPUTE:             cnt <= (cnt == 4'd11) ? 4'd0 : cnt + 4'd1;
        UNLOAD:  if (out_hs) cnt <= (cnt == 4'd7)  ? 4'd0 : cnt + 4'd1;
        default:             cnt <= '0;
      endcase
    end
  end

  // Direction flag is captured at start so a later change on 'inverse'
  // cannot corrupt a transform in flight.
`ifdef NTT_INTT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          inv_q <= 1'b0;
    else if (state == IDLE && ntt_start) inv_q <= inverse;
  end
`else
  assign inv_q = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Butterfly datapath
  // cnt[3:2] is the stage s (half-span m = 2^s), cnt[1:0] the butterfly b.
  // p = (b/m)*2m + b%m, q = p + m, twiddle exponent = (b%m) * 4/m.
  // ---------------------------------------------------------------------------
  logic [1:0]     stage, bf, tw_exp;
  logic [2:0]     idx_p, idx_q;
  logic [W-1:0]   tw, r_p, r_q, t, sum_m, diff_m;
  logic [2*W-1:0] prod;
  logic [W:0]     sum, diff;

  always_comb begin
    stage = cnt[3:2];
    bf    = cnt[1:0];
    case (stage)
      2'd0: begin
        idx_p  = {bf, 1'b0};
        idx_q  = {bf, 1'b1};
        tw_exp = 2'd0;
      end
      2'd1: begin
        idx_p  = {bf[1], 1'b0, bf[0]};
        idx_q  = {bf[1], 1'b1, bf[0]};
        tw_exp = {bf[0], 1'b0};
      end
      default: begin
        idx_p  = {1'b0, bf};
        idx_q  = {1'b1, bf};
        tw_exp = bf;
      end
    endcase

    case ({inv_q, tw_exp})
      3'b000:  tw = TWF0;
      3'b001:  tw = TWF1;
      3'b010:  tw = TWF2;
      3'b011:  tw = TWF3;
      3'b100:  tw = TWI0;
      3'b101:  tw = TWI1;
      3'b110:  tw = TWI2;
      default: tw = TWI3;
    endcase

    r_p  = rf[idx_p];
    r_q  = rf[idx_q];
    prod = {{W{1'b0}}, tw} * {{W{1'b0}}, r_q};
    t    = W'(prod % {{W{1'b0}}, QW});

    // Operands are already reduced, so one conditional subtract suffices.
    sum    = {1'b0, r_p} + {1'b0, t};
    sum_m  = (sum >= {1'b0, QW}) ? W'(sum - {1'b0, QW}) : W'(sum);
    diff   = {1'b0, r_p} + {1'b0, QW} - {1'b0, t};
    diff_m = (diff >= {1'b0, QW}) ? W'(diff - {1'b0, QW}) : W'(diff);
  end

  // ---------------------------------------------------------------------------
  // Register file: contents are don't-care after reset, so no reset branch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == LOAD && in_hs) begin
      rf[bitrev3(cnt[2:0])] <= in_data % QW;
    end else if (state == COMPUTE) begin
      rf[idx_p] <= sum_m;
      rf[idx_q] <= diff_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and FSM outputs
  // ---------------------------------------------------------------------------
  logic [W-1:0]   rd_raw, rd_scaled;
  logic [2*W-1:0] rd_prod;

  always_comb begin
    rd_raw    = rf[cnt[2:0]];
    rd_prod   = {{W{1'b0}}, rd_raw} * {{W{1'b0}}, NINV_W};
    rd_scaled = W'(rd_prod % {{W{1'b0}}, QW});

    in_ready  = (state == LOAD);
    out_valid = (state == UNLOAD);
    busy      = (state != IDLE);
    ntt_done  = done_q;
    dbg_state = state;
    // Gated so out_data reads 0 outside UNLOAD, including straight after reset.
    out_data  = out_valid ? (inv_q ? rd_scaled : rd_raw) : '0;
  end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed testbench for ntt_seq_ctrl: impulse, shifted impulse, constant
// input with input gaps and output back-pressure, out-of-range inputs,
// mid-transform reset, and (with NTT_INTT_EN) inverse transforms.

module tb_ntt_seq_ctrl;

  localparam int W = 8;
  typedef logic [W-1:0] vec_t [8];

  logic         clk;
  logic         rst_n;
  logic         ntt_start;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         ntt_done;
  logic [1:0]   dbg_state;
`ifdef NTT_INTT_EN
  logic         inverse;
`endif

  ntt_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ntt_start (ntt_start),
`ifdef NTT_INTT_EN
    .inverse   (inverse),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ntt_done  (ntt_done),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           last_beat_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
    end
  endtask

  task automatic push_vec(input vec_t e);
    for (int i = 0; i < 8; i++) exp_q.push_back(e[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic start_ntt(input logic inv);
    ntt_start = 1'b1;
`ifdef NTT_INTT_EN
    inverse = inv;
`else
    if (inv) $display("note: inverse requested without NTT_INTT_EN");
`endif
    @(negedge clk);
    ntt_start = 1'b0;
`ifdef NTT_INTT_EN
    inverse = ~inv;  // must be ignored once the transform has started
`endif
    check_eq("start_in_ready", in_ready, 1);
    check_eq("done_one_cycle", ntt_done, 0);
  endtask

  task automatic load_vec(input vec_t v, input bit gap, input bit poke_start);
    for (int i = 0; i < 8; i++) begin
      int guard;
      if (gap && i > 0) begin
        in_valid = 1'b0;
        in_data  = W'($urandom_range(0, 255));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = v[i];
      if (poke_start) ntt_start = (i == 4);
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check_eq("in_ready_timeout", 0, 1);
      last_beat_cyc = cyc;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    ntt_start = 1'b0;
    check_eq("in_ready_drop", in_ready, 0);
  endtask

  task automatic unload(input bit stall);
    int           guard;
    logic [W-1:0] held;
    out_ready = 1'b1;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("out_valid_timeout", 0, 1);
    check_eq("out_valid_latency", cyc - last_beat_cyc, 13);
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] exp_v;
      exp_v = exp_q.pop_front();
      if (stall && n == 3) begin
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_hold", out_data, held);
        end
        out_ready = 1'b1;
      end
      check_eq("out_valid", out_valid, 1);
      check_eq($sformatf("out_data[%0d]", n), out_data, exp_v);
      @(negedge clk);
    end
    check_eq("done_pulse", ntt_done, 1);
    check_eq("out_valid_drop", out_valid, 0);
    check_eq("busy_drop", busy, 0);
  endtask

`ifdef NTT_INTT_EN
  // Direct-sum reference transform.
  function automatic vec_t dft(input vec_t a, input bit inv);
    vec_t r;
    int   w, acc, p;
    w = inv ? 9 : 2;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        p = 1;
        for (int e = 0; e < (i * k) % 8; e++) p = (p * w) % 17;
        acc = (acc + (int'(a[i]) % 17) * p) % 17;
      end
      if (inv) acc = (acc * 15) % 17;
      r[k] = W'(acc);
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t v_imp, v_shift, v_ones, v_big, e_ones, e_shift, e_dc;
  int   seen_valid;

  initial begin
    rst_n     = 1'b0;
    ntt_start = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef NTT_INTT_EN
    inverse   = 1'b0;
`endif
    v_imp   = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_shift = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_ones  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    v_big   = '{8'd18, 8'd17, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e_ones  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    e_shift = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
    e_dc    = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", ntt_done, 0);
    check_eq("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse -> all ones
    start_ntt(1'b0);
    load_vec(v_imp, 1'b0, 1'b0);
    push_vec(e_ones);
    unload(1'b0);

    // Back-to-back: start in the done cycle; shifted impulse -> powers of 2
    start_ntt(1'b0);
    load_vec(v_shift, 1'b0, 1'b0);
    push_vec(e_shift);
    unload(1'b0);

    // Constant input, gapped input stream, output stall
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy, 0);
    start_ntt(1'b0);
    load_vec(v_ones, 1'b1, 1'b0);
    push_vec(e_dc);
    unload(1'b1);

    // Inputs at or above Q are reduced on load
    start_ntt(1'b0);
    load_vec(v_big, 1'b0, 1'b0);
    push_vec(e_ones);
    unload(1'b0);

    // Reset during COMPUTE
    start_ntt(1'b0);
    load_vec(v_shift, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("compute_state", dbg_state, 2);
    check_eq("compute_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_in_ready", in_ready, 0);
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_data", out_data, 0);
    check_eq("arst_done", ntt_done, 0);
    check_eq("arst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check_eq("no_partial_output", seen_valid, 0);

    // Fresh transform with ntt_start pulsed during LOAD
    start_ntt(1'b0);
    load_vec(v_shift, 1'b0, 1'b1);
    push_vec(e_shift);
    unload(1'b0);

`ifdef NTT_INTT_EN
    begin
      vec_t v_inv8, v_pi, e_fwd;
      v_inv8 = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      v_pi   = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
      e_fwd  = dft(v_pi, 1'b0);

      start_ntt(1'b1);
      load_vec(v_inv8, 1'b0, 1'b0);
      push_vec(e_ones);
      unload(1'b0);

      start_ntt(1'b0);
      load_vec(v_pi, 1'b0, 1'b0);
      push_vec(e_fwd);
      unload(1'b0);

      start_ntt(1'b1);
      load_vec(e_fwd, 1'b0, 1'b0);
      push_vec(v_pi);
      unload(1'b0);
    end
`endif

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
